// File: rtl/cmp_pkg.sv
// Shared definitions for the serial magnitude comparator: state encoding,
// the neutral cascade value and the counter width helper.
package cmp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCEPT = 2'd1;
  localparam state_t DONE   = 2'd2;

  // Cascade inputs {lin, ein, gin} meaning "all lower bytes equal".
  localparam logic [2:0] CASCADE_EQ = 3'b010;

  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/eight_bit_comparator.sv
// Cascadable 8-bit magnitude comparator: an unequal byte decides the result,
// an equal byte passes the cascade inputs through.
module eight_bit_comparator (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       lin,
  input  logic       ein,
  input  logic       gin,
  output logic       lout,
  output logic       eout,
  output logic       gout
);

  always_comb begin
    {lout, eout, gout} = {lin, ein, gin};
    if (a > b) begin
      {lout, eout, gout} = 3'b001;
    end else if (a < b) begin
      {lout, eout, gout} = 3'b100;
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Byte-serial magnitude comparator, LSB byte first, around eight_bit_comparator.
// Define SIGNED_CMP_EN for two's-complement operands.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_byte,
  input  logic [7:0] b_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       less,
  output logic       equal,
  output logic       greater,
  output logic       busy
);

  localparam int unsigned      CNT_W    = cnt_width(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       res;
  logic [2:0]       res_nxt;
  logic             is_last;
  logic             accept;
  logic [7:0]       a_cmp;
  logic [7:0]       b_cmp;

  assign is_last = (cnt == LAST_CNT);
  // A start in ACCEPT wins over a byte offered in the same cycle.
  assign accept  = (state == ACCEPT) && in_valid && !start;

`ifdef SIGNED_CMP_EN
  // Flipping both sign bits maps two's complement onto unsigned order.
  always_comb begin
    a_cmp = a_byte;
    b_cmp = b_byte;
    if (is_last) begin
      a_cmp[7] = ~a_byte[7];
      b_cmp[7] = ~b_byte[7];
    end
  end
`else
  always_comb begin
    a_cmp = a_byte;
    b_cmp = b_byte;
  end
`endif

  eight_bit_comparator u_cmp (
    .a    (a_cmp),
    .b    (b_cmp),
    .lin  (res[2]),
    .ein  (res[1]),
    .gin  (res[0]),
    .lout (res_nxt[2]),
    .eout (res_nxt[1]),
    .gout (res_nxt[0])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= CASCADE_EQ;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACCEPT;
            cnt   <= '0;
            res   <= CASCADE_EQ;
          end
        end
        ACCEPT: begin
          if (start) begin
            cnt <= '0;
            res <= CASCADE_EQ;
          end else if (accept) begin
            res <= res_nxt;
            if (is_last) begin
              state <= DONE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            if (start) begin
              state <= ACCEPT;
              cnt   <= '0;
              res   <= CASCADE_EQ;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          res   <= CASCADE_EQ;
        end
      endcase
    end
  end

  assign in_ready  = (state == ACCEPT);
  assign out_valid = (state == DONE);
  assign busy      = (state == ACCEPT) || (state == DONE);
  assign {less, equal, greater} = res;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator (NUM_BYTES=4), directed
// plus random operations against a whole-operand arithmetic model.
module tb_serial_magnitude_comparator;

  localparam int unsigned NB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a_byte = '0;
  logic [7:0] b_byte = '0;
  logic       in_ready, out_valid, less, equal, greater, busy;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_flags = 3'b010;
  bit         chained = 1'b0;

  serial_magnitude_comparator #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_byte    (a_byte),
    .b_byte    (b_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .less      (less),
    .equal     (equal),
    .greater   (greater),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {less,equal,greater} from the low n bytes of the operands.
  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b,
                                       input int unsigned n);
    logic [31:0] m, am, bm;
    bit sgn;
    m   = (n >= NB) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    am  = a & m;
    bm  = b & m;
    sgn = 1'b0;
`ifdef SIGNED_CMP_EN
    sgn = (n == NB);
`endif
    if (sgn) begin
      if ($signed(am) < $signed(bm)) return 3'b100;
      if ($signed(am) > $signed(bm)) return 3'b001;
      return 3'b010;
    end
    if (am < bm) return 3'b100;
    if (am > bm) return 3'b001;
    return 3'b010;
  endfunction

  // Every-cycle compare process.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {in_ready, out_valid, busy, less, equal, greater}, 6'b000010);
    end else begin
      check("onehot_flags", $countones({less, equal, greater}), 1);
      if (out_valid) check("result_flags", {less, equal, greater}, exp_flags);
    end
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit gaps_en,
                        input int unsigned hold, input bit chain_next, input logic [2:0] lit);
    int unsigned n, idx, gaps;
    logic [2:0] held;
    if (!chained) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chained   = 1'b0;
    exp_flags = model(a, b, NB);
    check("accept_entry", {in_ready, out_valid, busy}, 3'b101);
    check("cleared_flags", {less, equal, greater}, 3'b010);
    n = 1; idx = 0; gaps = 0;
    while (idx < NB && n < 64) begin
      if (gaps_en && (n % 2 == 0)) begin
        in_valid = 1'b0;
        gaps++;
      end else begin
        in_valid = 1'b1;
        a_byte   = a[8*idx +: 8];
        b_byte   = b[8*idx +: 8];
      end
      tick();
      n++;
      if (in_valid) idx++;
      if (idx < NB) begin
        check("in_ready_accept", in_ready, 1);
        check("partial_flags", {less, equal, greater}, model(a, b, idx));
      end
    end
    in_valid = 1'b0;
    while (!out_valid && n < 64) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", n, NB + 1 + gaps);
    if (lit != 3'b000) check("literal_result", {less, equal, greater}, lit);
    held = {less, equal, greater};
    for (int unsigned i = 0; i < hold; i++) begin
      start = 1'($urandom_range(0, 1));
      tick();
      check("hold_stable", {out_valid, less, equal, greater}, {1'b1, held});
    end
    out_ready = 1'b1;
    start     = chain_next;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    check("release", {out_valid, busy, in_ready}, {1'b0, chain_next, chain_next});
    chained = chain_next;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    int unsigned mode, k;
    logic [7:0] d;

    repeat (3) tick();
    check("reset_state", {in_ready, out_valid, busy, less, equal, greater}, 6'b000010);
    #2 rst_n = 1'b1;
    tick();
    check("idle_after_reset", {in_ready, out_valid, busy}, 3'b000);

    run_op(32'h12345678, 32'h12345679, 1'b0, 0, 1'b0, 3'b100);
    run_op(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0, 1'b0, 3'b010);
    run_op(32'h01000000, 32'h00FFFFFF, 1'b0, 0, 1'b0, 3'b001);
`ifdef SIGNED_CMP_EN
    run_op(32'h80000000, 32'h00000001, 1'b0, 0, 1'b0, 3'b100);
`else
    run_op(32'h80000000, 32'h00000001, 1'b0, 0, 1'b0, 3'b001);
`endif
    run_op(32'h12345678, 32'h12345679, 1'b1, 0, 1'b0, 3'b100);
    run_op(32'hDEADBEEF, 32'hDEADBEEE, 1'b0, 10, 1'b0, 3'b001);
    run_op(32'h00000005, 32'h00000007, 1'b0, 2, 1'b1, 3'b100);
    run_op(32'hCAFE0000, 32'hCAFE0000, 1'b0, 0, 1'b0, 3'b010);

    // Restart after two unequal bytes; the byte offered with start is dropped.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a_byte = 8'hFF; b_byte = 8'h00;
    tick();
    tick();
    start = 1'b1; a_byte = 8'h00; b_byte = 8'hFF;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("restart_flags", {less, equal, greater}, 3'b010);
    check("restart_state", {in_ready, out_valid, busy}, 3'b101);
    chained = 1'b1;
    run_op(32'h55555555, 32'h55555555, 1'b0, 0, 1'b0, 3'b010);

    // Asynchronous reset after three bytes.
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1; a_byte = 8'h10; b_byte = 8'h20;
    repeat (3) tick();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", {in_ready, out_valid, busy, less, equal, greater}, 6'b000010);
    tick();
    #2 rst_n = 1'b1;
    tick();
    run_op(32'h00000100, 32'h000000FF, 1'b0, 0, 1'b1, 3'b001);
    run_op(32'h00000001, 32'h00000002, 1'b0, 0, 1'b0, 3'b100);

    for (int unsigned it = 0; it < 40; it++) begin
      ra   = $urandom;
      mode = $urandom_range(0, 3);
      case (mode)
        0: rb = $urandom;
        1: rb = ra;
        2: begin
          k  = $urandom_range(0, NB - 1);
          d  = 8'($urandom_range(1, 255));
          rb = ra ^ (32'(d) << (8 * k));
        end
        default: rb = ra ^ 32'h8000_0000;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
             (it == 39) ? 1'b0 : 1'($urandom_range(0, 1)), 3'b000);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Byte-serial magnitude comparator for operands wider than one byte. Accepts NUM_BYTES byte pairs, least-significant byte first, over a valid/ready stream. Each byte pair is passed through the existing `eight_bit_comparator`, with the previous partial result fed into its lin/ein/gin cascade inputs. After the final (most-significant) byte it presents a held less/equal/greater result on an output valid/ready handshake, acting as the sequential stage that drives and consumes the 8-bit comparator.

## Interface
- NUM_BYTES, 4: operand width in bytes. Legal range is 1..256.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a new comparison.
- in_valid  input  1  a_byte/b_byte hold a valid byte pair.
- in_ready  output  1  block accepts a byte pair this cycle.
- a_byte  input  8  current byte of operand A, LSB byte first.
- b_byte  input  8  current byte of operand B, LSB byte first.
- out_valid  output  1  result is valid and held.
- out_ready  input  1  consumer takes the result.
- less, equal, greater  output  1 each  result flags; exactly one is high at all times.
- busy  output  1  high in ACCEPT and DONE.

## Operation
- FSM states: IDLE, ACCEPT, DONE.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start: go to ACCEPT, cnt<=0, result register {l,e,g}<=3'b010.
- ACCEPT:
  - in_ready=1.
  - A byte is accepted on in_valid && in_ready.
  - On acceptance: {l,e,g} <= comparator(a_byte, b_byte, lin=l, ein=e, gin=g). If the current byte pair is unequal, the current byte decides; otherwise the cascade value passes through.
  - After acceptance, cnt increments. If cnt==NUM_BYTES-1, go to DONE.
  - start in ACCEPT aborts the operation and restarts: cnt<=0, {l,e,g}<=3'b010. A byte offered in the same cycle is dropped.
- DONE:
  - out_valid=1; less/equal/greater are held stable.
  - On out_ready: go to IDLE. If start is also high in that cycle, go directly to ACCEPT with a cleared state.
  - start without out_ready is ignored.
- less/equal/greater always reflect the result register, including partial results during ACCEPT. Consumers must qualify the flags with out_valid.
- cnt width is max(1, $clog2(NUM_BYTES)). With NUM_BYTES=1, the first accepted byte moves the FSM to DONE.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, less=0, equal=1, greater=0. State=IDLE, cnt=0.
- Asserting rst_n low mid-operation aborts immediately to the reset values. No partial result survives.
- Minimum latency is NUM_BYTES+1 cycles from start to out_valid: 1 cycle to enter ACCEPT, then NUM_BYTES acceptance cycles.
- out_valid rises in the cycle after the last byte is accepted.
- Gaps in in_valid stall the block without altering state.
- Holding out_ready low holds out_valid and the flags indefinitely.
- Back-to-back operation: out_ready with start in DONE gives zero idle cycles between results.

## Configuration
- SIGNED_CMP_EN defined: operands are two's complement. When cnt==NUM_BYTES-1 (the MSB byte), bit 7 of both a_byte and b_byte is inverted before the comparator.
- SIGNED_CMP_EN undefined: unsigned comparison, and no inversion logic is present.

## Structure
- Shared package `cmp_pkg` holds:
  - state encoding typedef (IDLE/ACCEPT/DONE);
  - constant CASCADE_EQ = 3'b010 (lin, ein, gin);
  - function for the cnt width.
- Sub-module: one `eight_bit_comparator` instance, used unchanged. The FSM, counter, result register and optional sign-inversion logic live in `serial_magnitude_comparator`.

## Test plan
All scenarios use NUM_BYTES=4.
- A=0x12345678, B=0x12345679, bytes fed 78/79, 56/56, 34/34, 12/12 -> less=1 and out_valid on cycle 5 after start.
- A=B=0xDEADBEEF -> equal=1. Then A=0x01000000, B=0x00FFFFFF -> greater=1, because the MSB byte overrides the lower-byte less.
- A=0x80000000, B=0x00000001 -> greater=1 unsigned. With SIGNED_CMP_EN: less=1.
- Backpressure:
  - in_valid toggling 1,0,1,0,... -> same result, out_valid delayed by the gap count.
  - out_ready low for 10 cycles -> flags and out_valid stable throughout.
- start after 2 bytes -> restart. The next 4 bytes alone determine the result; cnt and flags reset to 0/equal.
- rst_n low after byte 3 -> all outputs at reset values asynchronously. A new start then completes normally. out_ready+start in DONE -> ACCEPT the next cycle.
